// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor computing diff = a - b, LSB first, one bit
//            per clock, with a single full-subtractor cell and a registered
//            borrow. Operands are taken on a start/done handshake; results
//            hold until the next operation completes.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - operation request, sampled only while idle
//            a, b   - minuend / subtrahend, captured on the accepting edge
//            busy   - operation in progress
//            done   - one-cycle completion pulse
//            diff   - (a - b) mod 2^WIDTH
//            bout   - final unsigned borrow (a < b)
//            ov     - signed overflow of the subtraction
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ov
);

    localparam int c_cnt_w = $clog2(WIDTH);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sd;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ov;
    logic               r_done;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_br_nxt;

    // Full-subtractor cell on the current LSBs of the operand shifters
    assign w_x      = r_sa[0];
    assign w_y      = r_sb[0];
    assign w_d      = w_x ^ w_y ^ r_br;
    assign w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_run;
                end
            end
            c_run: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Datapath: operand/result shifters, borrow, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sd   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ov   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_sa  <= a;
                r_sb  <= b;
                r_br  <= 1'b0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_sd  <= {w_d, r_sd[WIDTH-1:1]};
                r_br  <= w_br_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            // On the last bit the cell sees the operand MSBs, so the overflow
            // test uses the live cell inputs and output directly.
            if (w_last) begin
                r_diff <= {w_d, r_sd[WIDTH-1:1]};
                r_bout <= w_br_nxt;
                r_ov   <= (w_x != w_y) & (w_d != w_x);
            end
        end
    end

    assign busy = (r_state == c_run);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ov   = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8). A
//            behavioural arithmetic model is compared against the DUT on every
//            falling edge; directed vectors pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ov;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an operation accepted while idle finishes W edges
    // later with plain-arithmetic results.
    // ------------------------------------------------------------------
    logic         m_busy;
    logic         m_done;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_ov;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        logic [W:0] t;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_diff = '0;
            m_bout = 1'b0;
            m_ov   = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    t      = {1'b0, m_a} - {1'b0, m_b};
                    m_diff = t[W-1:0];
                    m_bout = t[W];
                    m_ov   = (m_a[W-1] != m_b[W-1]) && (m_diff[W-1] != m_a[W-1]);
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = W;
                m_a    = a;
                m_b    = b;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_busy});
            check("model_done", {31'd0, done}, {31'd0, m_done});
            check("model_diff", {24'd0, diff}, {24'd0, m_diff});
            check("model_bout", {31'd0, bout}, {31'd0, m_bout});
            check("model_ov",   {31'd0, ov},   {31'd0, m_ov});
        end
    end

    // Runs one operation from an idle state; n counts busy cycles.
    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string nm);
        int n;
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        n     = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check({nm, "_latency"}, n, W);
        check({nm, "_done"}, {31'd0, done}, 32'd1);
        check({nm, "_diff"}, {24'd0, diff}, {24'd0, ed});
        check({nm, "_bout"}, {31'd0, bout}, {31'd0, eb});
        check({nm, "_ov"},   {31'd0, ov},   {31'd0, eo});
        @(posedge clk); #1;
        check({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_diff", {24'd0, diff}, 32'd0);
        check("reset_bout", {31'd0, bout}, 32'd0);
        check("reset_ov",   {31'd0, ov},   32'd0);

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "basic");
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "borrow1");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "borrow2");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "ovf1");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "ovf2");

        // start pulse while busy must be ignored
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 3) begin
                a     = 8'h01;
                b     = 8'h01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_start_latency", n, W);
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_diff", {24'd0, diff}, 32'h55);
        check("busy_start_bout", {31'd0, bout}, 32'd0);
        check("busy_start_ov",   {31'd0, ov},   32'd1);
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("busy_start_no_second_done", dcnt, 0);

        // back-to-back with start held high; first result must hold during the second
        a     = 8'h09;
        b     = 8'h04;
        start = 1'b1;
        @(posedge clk); #1;
        a = 8'h04;
        b = 8'h09;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("b2b_first_latency", n, W);
        check("b2b_first_done", {31'd0, done}, 32'd1);
        check("b2b_first_diff", {24'd0, diff}, 32'h05);
        check("b2b_first_bout", {31'd0, bout}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        while (busy && n < 40) begin
            check("b2b_hold_diff", {24'd0, diff}, 32'h05);
            n++;
            @(posedge clk); #1;
        end
        check("b2b_second_latency", n, W);
        check("b2b_second_done", {31'd0, done}, 32'd1);
        check("b2b_second_diff", {24'd0, diff}, 32'hFB);
        check("b2b_second_bout", {31'd0, bout}, 32'd1);
        @(posedge clk); #1;

        // asynchronous reset in the middle of an operation
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_diff", {24'd0, diff}, 32'd0);
        check("rst_mid_bout", {31'd0, bout}, 32'd0);
        check("rst_mid_ov",   {31'd0, ov},   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcnt  = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("rst_mid_no_done", dcnt, 0);
        run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, "after_rst");

        // a few random operations checked by the model only
        for (int i = 0; i < 6; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n     = 0;
            while (busy && n < 40) begin
                n++;
                @(posedge clk); #1;
            end
            check("rand_latency", n, W);
            @(posedge clk); #1;
        end

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
